out_unit_np: RTL
================

# out_unit_np

Parametrised router output-port unit: an N-input crossbar column feeding a small output FIFO and a registered output stage. It buffers flits against downstream backpressure (`full`) and gives upstream switch allocation a `in_ready` signal. It sits between the switch allocator and the output link of each router port, replacing fixed 4-port, unbuffered output units.

## Interface
- `DATA_WIDTH`, default 16: flit width in bits.
- `NUM_IN`, default 4: number of crossbar inputs (1..15).
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `SEL_W`, derived = clog2(NUM_IN+1): select width.
- `CNT_W`, derived = clog2(FIFO_DEPTH+1): occupancy width.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sel_id`  in  SEL_W  0 = stop; k in 1..NUM_IN selects input k-1; any value >NUM_IN is illegal.
- `data_in`  in  NUM_IN*DATA_WIDTH  packed inputs; input i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `full`  in  1  downstream cannot accept; output stage holds.
- `in_ready`  out  1  combinational; 1 when FIFO count < FIFO_DEPTH.
- `data_out`  out  DATA_WIDTH  registered output flit.
- `data_valid`  out  1  registered; data_out carries a flit.
- `fifo_count`  out  CNT_W  registered FIFO occupancy.
- `sel_err`  out  1  registered one-cycle pulse when sel_id > NUM_IN.

## Operation
- Crossbar: combinational mux of `data_in` by `sel_id`. Stop or illegal selects produce 0 and no push.
- Push: when sel_id is in 1..NUM_IN and in_ready=1, the selected flit is written at wr_ptr and wr_ptr increments mod FIFO_DEPTH.
- Push is refused when the FIFO is full. in_ready=0 and nothing is written. Upstream must hold sel_id/data until in_ready=1.
- Pop: when full=0 and count>0, the head flit is loaded into data_out, data_valid<=1 and rd_ptr increments.
- When full=0 and count=0: data_out<=0 and data_valid<=0.
- When full=1: data_out, data_valid and rd_ptr hold, and there is no pop. Pushes continue while in_ready=1.
- Count update: push only +1; pop only -1; push and pop in the same cycle leaves it unchanged.
- in_ready uses the count before the edge. A cycle with count=FIFO_DEPTH and a pop does not accept a push; there is no full-bypass.
- No FIFO bypass: a flit always passes through one FIFO entry.
- sel_err <= (sel_id > NUM_IN) every cycle, independent of full and in_ready.
- Reset (async assert, any time including mid-transfer):
  - data_out=0, data_valid=0, fifo_count=0, sel_err=0.
  - Pointers are cleared and FIFO contents are discarded.
  - in_ready=1 while in reset.
  - Storage array needs no reset.

## Timing
- Pushed at edge E with empty FIFO and full=0: the flit appears on data_out/data_valid after edge E+1 (2-edge latency from sel_id presentation).
- Throughput: 1 flit/cycle sustained while full=0.
- full sampled at edge: if full=1 at edge E, outputs at E+1 equal outputs before E.
- fifo_count reflects state after each edge. in_ready changes combinationally with it.
- Ordering: strict FIFO; flits leave in push order regardless of source input.

## Test plan
- Reset/idle (NUM_IN=4, W=16, DEPTH=4): assert rst_n=0 mid-stream with count=3 -> data_out=0, data_valid=0, fifo_count=0, in_ready=1. Release with sel_id=0 -> outputs stay 0.
- Per-input select: sel_id=1..4 on consecutive cycles with data_in slices 0xA001,0xA002,0xA003,0xA004, full=0 -> data_out shows 0xA001..0xA004 on consecutive cycles, first valid 2 edges after the first push, then data_valid=0.
- Backpressure fill: full=1, push 0x0011..0x0014 -> fifo_count reaches 4 and in_ready=0. A fifth push of 0x0015 is held (not written). Drop full -> 0x0011..0x0014 then 0x0015 emerge in order, none lost or duplicated.
- Full hold: data_valid=1 with data_out=0xBEEF, raise full for 3 cycles -> data_out=0xBEEF and data_valid=1 held. Release -> the next head flit follows.
- Simultaneous push/pop at count=2, full=0 -> fifo_count stays 2 and order is preserved. At count=4 with pop and push requested -> push refused and count becomes 3.
- Illegal select: sel_id=5 with NUM_IN=4 -> sel_err=1 for exactly the cycle after, no push, fifo_count unchanged.

Source files
------------

// File: rtl/out_unit_np_if.sv
// Bus between the switch allocator / output link and one router output-port
// unit: crossbar select and data in, downstream backpressure in, registered
// flit stream and status out.
interface out_unit_np_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int SEL_W = $clog2(NUM_IN + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [SEL_W-1:0]             sel_id;
  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic                         full;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         data_valid;
  logic [CNT_W-1:0]             fifo_count;
  logic                         sel_err;

  modport master (
    output sel_id, data_in, full,
    input  in_ready, data_out, data_valid, fifo_count, sel_err
  );

  modport slave (
    input  sel_id, data_in, full,
    output in_ready, data_out, data_valid, fifo_count, sel_err
  );
endinterface

// File: rtl/out_unit_np.sv
// Router output-port unit: an NUM_IN-input crossbar column writes the selected
// flit into a small FIFO; a registered output stage drains it whenever the
// downstream link is not asserting full. Every flit passes through one FIFO
// entry, so a flit pushed into an empty FIFO leaves two edges after its select.
module out_unit_np #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  out_unit_np_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  sel_err_q, sel_err_d;

  logic [DATA_WIDTH-1:0] sel_flit;
  logic                  sel_legal;
  logic                  in_ready;
  logic                  push;
  logic                  pop;

  // Acceptance depends only on occupancy before the edge, so a full FIFO
  // refuses a push even in a cycle where it also pops.
  assign in_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign sel_legal = (bus.sel_id != '0) && (bus.sel_id <= SEL_W'(NUM_IN));
  assign push = sel_legal && in_ready;
  assign pop = !bus.full && (count_q != '0);

  // Crossbar column: select k picks input k-1; stop and illegal selects give 0.
  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel_id == SEL_W'(i + 1)) begin
        sel_flit = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state for FIFO storage, pointers, occupancy and the output stage.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    sel_err_d    = (bus.sel_id > SEL_W'(NUM_IN));

    if (push) begin
      mem_d[wr_ptr_q] = sel_flit;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (!bus.full) begin
      if (pop) begin
        data_out_d   = mem_q[rd_ptr_q];
        data_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      end else begin
        data_out_d   = '0;
        data_valid_d = 1'b0;
      end
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers, cleared asynchronously so a reset mid-transfer
  // discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.fifo_count = count_q;
  assign bus.sel_err    = sel_err_q;
endmodule
